// File: rtl/sd_io_arbiter.sv
// sd_io_arbiter
// Shares the io controller's single SD sector-transfer channel between N
// SCSI targets. Requests are granted one at a time, round-robin from a
// rotating pointer. The granted target's LBA and direction go to the io
// controller. Ack, buffer write strobes and buffer read data are routed
// only between the io controller and the granted target.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   req_rd        per-target sector read request (level)
//   req_wr        per-target sector write request (level)
//   req_lba       per-target LBA, target i at [32*i+31:32*i]
//   req_ack       per-target ack (granted target only)
//   req_buff_din  per-target buffer read data, target i at [8*i+7:8*i]
//   req_buff_wr   per-target buffer write strobe (granted target only)
//   sd_rd         registered read command to io controller
//   sd_wr         registered write command to io controller
//   sd_lba        LBA latched at grant time
//   sd_drive      index of the granted target
//   sd_ack        io controller ack, high for the whole sector transfer
//   sd_buff_wr    io controller buffer write strobe
//   sd_buff_din   buffer read data from the granted target
//   busy          high whenever the arbiter is not idle
module sd_io_arbiter #(
   parameter int N    = 2,
   parameter int IDXW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req_rd,
   input  logic [N-1:0]      req_wr,
   input  logic [32*N-1:0]   req_lba,
   output logic [N-1:0]      req_ack,
   input  logic [8*N-1:0]    req_buff_din,
   output logic [N-1:0]      req_buff_wr,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic [31:0]       sd_lba,
   output logic [IDXW-1:0]   sd_drive,
   input  logic              sd_ack,
   input  logic              sd_buff_wr,
   output logic [7:0]        sd_buff_din,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

   state_t            state, state_nxt;
   logic [IDXW-1:0]   ptr, ptr_nxt;
   logic [IDXW-1:0]   grant, grant_nxt;
   logic              sd_rd_nxt, sd_wr_nxt;
   logic [31:0]       sd_lba_nxt;

   logic [N-1:0]      pending;
   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;
   logic [31:0]       pick_lba;
   logic              pick_rd;
   int                pick_dist;
   int                best_dist;
   logic              active;

   assign pending  = req_rd | req_wr;
   assign sd_drive = grant;
   assign busy     = (state != IDLE);
   assign active   = (state == ISSUE) || (state == XFER);

   // Round-robin search: the pending target with the smallest distance
   // upward from ptr (modulo N) wins. A read beats a write on the same target.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_lba   = '0;
      pick_rd    = 1'b0;
      pick_dist  = 0;
      best_dist  = N;
      for (int i = 0; i < N; i++) begin
         if (pending[i]) begin
            pick_dist = (i + N - int'(ptr)) % N;
            if (pick_dist < best_dist) begin
               best_dist  = pick_dist;
               pick_found = 1'b1;
               pick_idx   = IDXW'(i);
               pick_lba   = req_lba[32*i +: 32];
               pick_rd    = req_rd[i];
            end
         end
      end
   end

   // Next-state logic. The command and LBA are latched once on grant and
   // then held; later request or LBA changes are ignored until the next grant.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      grant_nxt  = grant;
      sd_rd_nxt  = sd_rd;
      sd_wr_nxt  = sd_wr;
      sd_lba_nxt = sd_lba;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_nxt  = pick_idx;
               sd_lba_nxt = pick_lba;
               sd_rd_nxt  = pick_rd;
               sd_wr_nxt  = ~pick_rd;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            if (sd_ack) begin
               sd_rd_nxt = 1'b0;
               sd_wr_nxt = 1'b0;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (!sd_ack) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            ptr_nxt   = IDXW'((int'(grant) + 1) % N);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and command registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         grant  <= '0;
         sd_rd  <= 1'b0;
         sd_wr  <= 1'b0;
         sd_lba <= '0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         grant  <= grant_nxt;
         sd_rd  <= sd_rd_nxt;
         sd_wr  <= sd_wr_nxt;
         sd_lba <= sd_lba_nxt;
      end
   end

   // Routing between the io controller and the granted target. Outside
   // ISSUE/XFER nothing is routed, so stray acks never reach a target.
   always_comb begin
      req_ack     = '0;
      req_buff_wr = '0;
      sd_buff_din = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (active && (grant == IDXW'(i))) begin
            req_ack[i]     = sd_ack;
            req_buff_wr[i] = sd_buff_wr;
            sd_buff_din    = req_buff_din[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sd_io_arbiter.sv
// tb_sd_io_arbiter
// Self-checking bench for sd_io_arbiter with two targets. Expected commands
// are queued when requests are driven and compared when the arbiter issues
// them; routing, timing and reset behaviour are checked directly.
module tb_sd_io_arbiter;

   localparam int N    = 2;
   localparam int IDXW = 3;

   logic              clk;
   logic              reset;
   logic [N-1:0]      req_rd;
   logic [N-1:0]      req_wr;
   logic [32*N-1:0]   req_lba;
   logic [N-1:0]      req_ack;
   logic [8*N-1:0]    req_buff_din;
   logic [N-1:0]      req_buff_wr;
   logic              sd_rd;
   logic              sd_wr;
   logic [31:0]       sd_lba;
   logic [IDXW-1:0]   sd_drive;
   logic              sd_ack;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din;
   logic              busy;

   typedef struct {
      logic [IDXW-1:0] drive;
      logic            rd;
      logic            wr;
      logic [31:0]     lba;
   } exp_t;

   exp_t exp_q[$];

   int check_count;
   int pass_count;
   int pulses0;
   int pulses1;
   logic prev_cmd;

   localparam logic [31:0] LBA0 = 32'h0000ABCD;
   localparam logic [31:0] LBA1 = 32'h00001234;

   sd_io_arbiter #(.N(N), .IDXW(IDXW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_rd       (req_rd),
      .req_wr       (req_wr),
      .req_lba      (req_lba),
      .req_ack      (req_ack),
      .req_buff_din (req_buff_din),
      .req_buff_wr  (req_buff_wr),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_lba       (sd_lba),
      .sd_drive     (sd_drive),
      .sd_ack       (sd_ack),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din),
      .busy         (busy)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      else
         pass_count++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr);
      req_rd = rd;
      req_wr = wr;
   endtask

   task automatic pushExp(input int drive, input logic rd, input logic wr, input logic [31:0] lba);
      exp_t e;
      e.drive = IDXW'(drive);
      e.rd    = rd;
      e.wr    = wr;
      e.lba   = lba;
      exp_q.push_back(e);
   endtask

   // Scoreboard side: every new command issued is compared with the oldest
   // expected one
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_cmd = 1'b0;
      end else begin
         if ((sd_rd | sd_wr) && !prev_cmd) begin
            if (exp_q.size() == 0) begin
               checkOutput("sb_unexpected_cmd", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("sb_drive", 64'(sd_drive), 64'(e.drive));
               checkOutput("sb_rd", 64'(sd_rd), 64'(e.rd));
               checkOutput("sb_wr", 64'(sd_wr), 64'(e.wr));
               checkOutput("sb_lba", 64'(sd_lba), 64'(e.lba));
            end
         end
         prev_cmd = sd_rd | sd_wr;
      end
   end

   // io controller model for one transfer on target g: wait for the
   // command, ack after ack_delay cycles for ack_len cycles, optionally
   // pulse the buffer strobe, and follow the arbiter through GAP to IDLE
   task automatic runTransfer(input int g, input int ack_delay, input int ack_len,
                              input int pulses, input logic [N-1:0] clr_rd,
                              input logic [N-1:0] clr_wr, output int waited);
      logic [N-1:0] mask;
      mask   = N'(1 << g);
      waited = 0;
      while (!(sd_rd | sd_wr) && waited < 20) begin
         tick();
         waited++;
      end
      if (!(sd_rd | sd_wr)) begin
         checkOutput("cmd_timeout", 64'd0, 64'd1);
         return;
      end
      checkOutput("issue_busy", 64'(busy), 64'd1);
      repeat (ack_delay) begin
         tick();
         checkOutput("issue_hold", 64'(sd_rd | sd_wr), 64'd1);
         checkOutput("issue_no_ack", 64'(req_ack), 64'd0);
      end
      sd_ack = 1'b1;
      req_rd = req_rd & ~clr_rd;
      req_wr = req_wr & ~clr_wr;
      #1;
      checkOutput("ack_route_issue", 64'(req_ack), 64'(mask));
      for (int c = 0; c < ack_len; c++) begin
         tick();
         if (c == 0)
            checkOutput("cmd_cleared", 64'(sd_rd | sd_wr), 64'd0);
         sd_buff_wr = (c < 2 * pulses) && (c % 2 == 0);
         #1;
         checkOutput("ack_route_xfer", 64'(req_ack), 64'(mask));
         checkOutput("buff_wr_route", 64'(req_buff_wr), sd_buff_wr ? 64'(mask) : 64'd0);
         checkOutput("buff_din_route", 64'(sd_buff_din), 64'(req_buff_din[8*g +: 8]));
         if (req_buff_wr[0]) pulses0++;
         if (req_buff_wr[1]) pulses1++;
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      #1;
      checkOutput("ack_release", 64'(req_ack), 64'd0);
      tick();
      checkOutput("gap_busy", 64'(busy), 64'd1);
      tick();
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_buff_din", 64'(sd_buff_din), 64'd0);
   endtask

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      int waited;
      int n;
      check_count  = 0;
      pass_count   = 0;
      pulses0      = 0;
      pulses1      = 0;
      prev_cmd     = 1'b0;
      reset        = 1'b1;
      req_rd       = '0;
      req_wr       = '0;
      req_lba      = {LBA1, LBA0};
      req_buff_din = {8'hA5, 8'h3C};
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;

      // Reset values before any clock edge
      #3;
      checkOutput("rst_sd_rd", 64'(sd_rd), 64'd0);
      checkOutput("rst_sd_wr", 64'(sd_wr), 64'd0);
      checkOutput("rst_sd_lba", 64'(sd_lba), 64'd0);
      checkOutput("rst_sd_drive", 64'(sd_drive), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_req_ack", 64'(req_ack), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      $display("[TB] single read on target 1");
      applyStimulus(2'b10, 2'b00);
      pushExp(1, 1'b1, 1'b0, LBA1);
      runTransfer(1, 3, 10, 0, 2'b10, 2'b00, waited);
      checkOutput("single_latency", 64'(waited), 64'd1);

      $display("[TB] simultaneous reads from ptr 0");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      applyStimulus(2'b11, 2'b00);
      pushExp(0, 1'b1, 1'b0, LBA0);
      pushExp(1, 1'b1, 1'b0, LBA1);
      pushExp(0, 1'b1, 1'b0, LBA0);
      runTransfer(0, 1, 3, 0, 2'b00, 2'b00, waited);
      checkOutput("rr_first_latency", 64'(waited), 64'd1);
      runTransfer(1, 1, 3, 0, 2'b10, 2'b00, waited);
      checkOutput("rr_gap_spacing_1", 64'(waited), 64'd1);
      runTransfer(0, 1, 3, 0, 2'b01, 2'b00, waited);
      checkOutput("rr_gap_spacing_2", 64'(waited), 64'd1);

      $display("[TB] direction priority and buffer routing");
      applyStimulus(2'b01, 2'b01);
      pushExp(0, 1'b1, 1'b0, LBA0);
      runTransfer(0, 2, 4, 0, 2'b01, 2'b01, waited);
      pulses0 = 0;
      pulses1 = 0;
      applyStimulus(2'b00, 2'b10);
      pushExp(1, 1'b0, 1'b1, LBA1);
      runTransfer(1, 2, 10, 4, 2'b00, 2'b10, waited);
      checkOutput("buff_pulses_t1", 64'(pulses1), 64'd4);
      checkOutput("buff_pulses_t0", 64'(pulses0), 64'd0);

      $display("[TB] withdrawn request on target 0");
      applyStimulus(2'b01, 2'b00);
      pushExp(0, 1'b1, 1'b0, LBA0);
      tick();
      checkOutput("wd_issue_rd", 64'(sd_rd), 64'd1);
      tick();
      req_rd = 2'b00;
      tick();
      checkOutput("wd_rd_held", 64'(sd_rd), 64'd1);
      checkOutput("wd_drive", 64'(sd_drive), 64'd0);
      runTransfer(0, 2, 4, 0, 2'b00, 2'b00, waited);
      // ptr should now be 1, so target 1 wins a tie
      applyStimulus(2'b11, 2'b00);
      pushExp(1, 1'b1, 1'b0, LBA1);
      pushExp(0, 1'b1, 1'b0, LBA0);
      runTransfer(1, 1, 3, 0, 2'b10, 2'b00, waited);
      runTransfer(0, 1, 3, 0, 2'b01, 2'b00, waited);

      $display("[TB] reset during XFER");
      applyStimulus(2'b01, 2'b00);
      pushExp(0, 1'b1, 1'b0, LBA0);
      n = 0;
      while (!(sd_rd | sd_wr) && n < 20) begin
         tick();
         n++;
      end
      checkOutput("rx_cmd_seen", 64'(sd_rd), 64'd1);
      sd_ack = 1'b1;
      tick();
      req_rd = 2'b11;
      tick();
      checkOutput("rx_xfer_ack", 64'(req_ack), 64'd1);
      checkOutput("rx_xfer_busy", 64'(busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rx_sd_rd", 64'(sd_rd), 64'd0);
      checkOutput("rx_sd_wr", 64'(sd_wr), 64'd0);
      checkOutput("rx_req_ack", 64'(req_ack), 64'd0);
      checkOutput("rx_busy", 64'(busy), 64'd0);
      checkOutput("rx_sd_lba", 64'(sd_lba), 64'd0);
      sd_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      // ptr restarts at 0, so target 0 goes first despite the last grant
      pushExp(0, 1'b1, 1'b0, LBA0);
      pushExp(1, 1'b1, 1'b0, LBA1);
      runTransfer(0, 1, 3, 0, 2'b01, 2'b00, waited);
      runTransfer(1, 1, 3, 0, 2'b10, 2'b00, waited);

      tick();
      tick();
      checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/sd_io_arbiter.md
Name: sd_io_arbiter

Overview:
Shares the single SD-card sector-transfer channel of the io controller between N SCSI target instances behind the NCR5380 model (targets 2 and 6 today).
- Each target issues independent sector read/write requests.
- The arbiter grants one target at a time, round-robin, and presents its LBA and direction to the io controller.
- For the duration of the transfer, it routes ack, buffer write strobes and buffer read data between the io controller and the granted target only.

Parameters:
N, 2, number of requesters (targets); 1 to 8.
IDXW, 3, width of sd_drive index output; must satisfy 2^IDXW >= N.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_rd  in  N  per-target sector read request (level)
req_wr  in  N  per-target sector write request (level)
req_lba  in  32*N  per-target LBA; target i occupies bits [32*i+31:32*i]
req_ack  out  N  per-target ack
req_buff_din  in  8*N  per-target buffer read data (target -> SD write path)
req_buff_wr  out  N  per-target buffer write strobe
sd_rd  out  1  read command to io controller
sd_wr  out  1  write command to io controller
sd_lba  out  32  LBA to io controller
sd_drive  out  IDXW  index of granted target
sd_ack  in  1  io controller ack; high for the whole 512-byte transfer
sd_buff_wr  in  1  io controller buffer write strobe
sd_buff_din  out  8  buffer read data to io controller
busy  out  1  high while any state other than IDLE

Behaviour:
- States and transitions:
  - IDLE: if any req_rd|req_wr bit is set, pick the first pending index searching from ptr upward, wrapping modulo N.
    - On that edge: latch grant index, sd_lba <= req_lba[grant], assert sd_rd or sd_wr (registered), go to ISSUE.
    - If both rd and wr are set for the chosen index, rd wins.
  - ISSUE: hold sd_rd/sd_wr, sd_lba and sd_drive stable.
    - On the first cycle sd_ack=1: clear sd_rd/sd_wr (registered) and go to XFER.
  - XFER: wait for sd_ack=0, then go to GAP.
  - GAP: one cycle. Set ptr <= (grant+1) mod N, then go to IDLE.
- Latency:
  - Request seen in IDLE at edge k produces sd_rd/sd_wr high after edge k.
  - Minimum request-to-request spacing is ISSUE + XFER + GAP + 1 IDLE cycle.
- Routing (combinational on registered grant):
  - req_ack[i] = sd_ack & (state is ISSUE or XFER) & (grant == i).
  - req_buff_wr[i] = sd_buff_wr & (state is ISSUE or XFER) & (grant == i).
  - sd_buff_din = req_buff_din[grant] in ISSUE/XFER, else 8'h00.
  - Non-granted targets always see ack=0 and buff_wr=0.
- Commitment:
  - Once ISSUE is entered the command is committed.
  - Deasserting req_rd/req_wr during ISSUE/XFER does not abort; the transfer completes and is routed normally.
  - Changes on req_lba after the latch are ignored.
- sd_ack=1 while in IDLE or GAP is ignored and does not change state.
- Out-of-range grant is impossible; pending indices >= N do not exist.
- Reset values (asynchronous):
  - state=IDLE, ptr=0, grant=0.
  - sd_rd=0, sd_wr=0, sd_lba=0, sd_drive=0, busy=0.
  - All req_ack/req_buff_wr = 0.
- Reset mid-transfer: immediately forces the reset values above; no completion is signalled to the requester.
- With N=1: ptr is constant 0 and behaviour is otherwise identical.

Test Plan:
- Single read:
  - Stimulus: req_rd[1]=1, req_lba[63:32]=0x00001234; io model acks 3 cycles later for 10 cycles.
  - Required: sd_rd=1, sd_lba=0x1234, sd_drive=1 one edge after request.
  - Required: sd_rd drops the edge after sd_ack rises; req_ack[1] mirrors sd_ack and req_ack[0] stays 0; busy returns 0 two cycles after sd_ack falls.
- Simultaneous requests:
  - Stimulus: req_rd=2'b11 from reset (ptr=0), all held until acked.
  - Required: target 0 served first, then target 1, then target 0 again if still pending.
  - Required: exactly one GAP cycle between each transfer.
- Direction and priority:
  - Stimulus: req_rd[0]=1 and req_wr[0]=1 together.
  - Required: sd_rd=1, sd_wr=0.
  - Stimulus: later req_wr[1] alone.
  - Required: sd_wr=1, sd_rd=0.
- Buffer routing:
  - Stimulus: during a target-1 write, req_buff_din = {8'hA5, 8'h3C}; pulse sd_buff_wr 4 times.
  - Required: sd_buff_din=8'hA5; req_buff_wr[1] pulses 4 times and req_buff_wr[0] never pulses.
  - Required: sd_buff_din=8'h00 in IDLE.
- Withdrawn request:
  - Stimulus: req_rd[0] dropped 1 cycle into ISSUE.
  - Required: sd_rd stays high until sd_ack=1; transfer routes to target 0; ptr advances to 1.
- Reset mid-XFER:
  - Stimulus: assert reset while sd_ack=1 in XFER.
  - Required: same cycle, sd_rd=sd_wr=0, req_ack=0, busy=0, sd_lba=0.
  - Required: after reset, a pending req_rd[1] is served with ptr starting at 0.
